// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage RV64 pipeline.
// Owns the PC, issues one word read at a time on the instruction bus, and
// buffers each returned word with its PC in a small FIFO. Decode takes
// entries through a valid/ready handshake. A redirect flushes all
// wrong-path work. A redirect that arrives while a read is still in flight
// parks the FSM in DISCARD until that stale read completes, because the bus
// does not allow a request to be withdrawn.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   ireq_valid      instruction read request (held until iresp_data_ok)
//   ireq_addr       read address (pc, or the stale address while discarding)
//   iresp_data_ok   completes the outstanding request
//   iresp_data      instruction word, valid with iresp_data_ok
//   redirect_valid  load redirect_pc and flush
//   redirect_pc     redirect target
//   out_valid       out_data holds a valid instruction
//   out_data        {instruction[95:64], pc[63:0]}
//   out_ready       decode accepts out_data this cycle
//
// state   | meaning
// FETCH   | normal fetching; responses are pushed into the FIFO
// DISCARD | wrong-path read still on the bus; its response is dropped
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [95:0] out_data,
  input  logic        out_ready
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD       = CW'(QDEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

  typedef enum logic {FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [63:0] pc;
  } fetch_data_t;

  state_t        state;
  logic [63:0]   pc;
  logic [63:0]   stale_addr;
  logic          pending;
  fetch_data_t   fifo [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A request already on the bus stays up until completed. Otherwise a new
  // one starts only if a FIFO slot is free. The slot stays reserved, because
  // only responses push and pops can only free more room.
  assign ireq_valid = (state == DISCARD) || pending || (count < QD);
  assign ireq_addr  = (state == DISCARD) ? stale_addr : pc;

  assign out_valid = (count != '0);
  assign out_data  = fifo[rd_ptr];

  assign push = ireq_valid && iresp_data_ok && (state == FETCH) && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= PC_RESET;
      stale_addr <= PC_RESET;
      pending    <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect_valid) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pc      <= redirect_pc;
      pending <= 1'b0;
      // In-flight read that is not completing now: remember its address so
      // it can be held on the bus until the response arrives.
      if (ireq_valid && !iresp_data_ok) begin
        state      <= DISCARD;
        stale_addr <= ireq_addr;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          pending <= ireq_valid && !iresp_data_ok;
          if (push) begin
            fifo[wr_ptr] <= {iresp_data, pc};
            wr_ptr       <= ptr_next(wr_ptr);
            pc           <= pc + 64'd4;
          end
        end
        DISCARD: begin
          if (iresp_data_ok) begin
            state   <= FETCH;
            pending <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase

      if (pop) rd_ptr <= ptr_next(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit. The stimulus thread pushes expected PCs.
// A monitor pops and compares them on each output handshake. A bus model
// answers requests with a word derived from the address. A checker watches
// that a request stays stable until it completes.
module tb_fetch_unit;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [95:0] out_data;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];
  int grant_left = 0;
  int lat        = 0;
  int wait_cnt   = 0;

  fetch_unit #(.PC_RESET(PC_RESET), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5555_AAAA;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus model: answers after 'lat' wait cycles, only while grants remain.
  always @(negedge clk) begin
    #2;
    if (reset || !ireq_valid) begin
      iresp_data_ok = 1'b0;
      wait_cnt      = 0;
    end else if (wait_cnt >= lat && grant_left > 0) begin
      iresp_data_ok = 1'b1;
      iresp_data    = word_of(ireq_addr);
      grant_left--;
      wait_cnt      = 0;
    end else begin
      iresp_data_ok = 1'b0;
      wait_cnt++;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    logic [63:0] e;
    #3;
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h expected no output", out_data[63:0]);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_data[63:0], e);
        check("out_instr", {32'h0, out_data[95:64]}, {32'h0, word_of(e)});
      end
    end
  end

  // Bus rule: an uncompleted request stays up with the same address.
  logic        prev_valid = 1'b0;
  logic        prev_ok    = 1'b0;
  logic        prev_reset = 1'b1;
  logic [63:0] prev_addr  = '0;
  always @(negedge clk) begin
    #3;
    if (prev_valid && !prev_ok && !prev_reset) begin
      check("bus_hold_valid", {63'h0, ireq_valid}, 64'h1);
      check("bus_hold_addr", ireq_addr, prev_addr);
    end
    prev_valid = ireq_valid;
    prev_ok    = iresp_data_ok;
    prev_reset = reset;
    prev_addr  = ireq_addr;
  end

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    grant_left     = 0;
    out_ready      = 1'b1;
    lat            = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #4;
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int cycles;

    // Reset state
    do_reset();
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_ireq_valid", {63'h0, ireq_valid}, 64'h1);
    check("rst_ireq_addr", ireq_addr, PC_RESET);

    // 1: sequential fetch, bus answers one cycle after each request
    lat        = 1;
    grant_left = 3;
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    exp_q.push_back(64'h8000_0008);
    wait_drain("t1_drain");
    check("t1_next_addr", ireq_addr, 64'h8000_000C);

    // Throughput: zero-latency bus, 4 instructions in 4 cycles
    do_reset();
    grant_left = 4;
    for (int k = 0; k < 4; k++) exp_q.push_back(PC_RESET + 64'(4 * k));
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #4;
      cycles = i + 1;
      if (exp_q.size() == 0) break;
    end
    check("tput_cycles", (cycles <= 4) ? 64'h1 : 64'h0, 64'h1);

    // 2: decode stalls, FIFO fills to 2, no request while full
    do_reset();
    out_ready  = 1'b0;
    grant_left = 2;
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    repeat (10) @(negedge clk);
    check("t2_full_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    check("t2_full_out_valid", {63'h0, out_valid}, 64'h1);
    check("t2_head_pc", out_data[63:0], 64'h8000_0000);
    out_ready = 1'b1;
    wait_drain("t2_drain");
    check("t2_next_addr", ireq_addr, 64'h8000_0008);

    // 3: redirect while a request waits; stale data dropped
    do_reset();
    grant_left = 2;
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    wait_drain("t3_pre_drain");
    check("t3_wait_addr", ireq_addr, 64'h8000_0008);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      check("t3_stale_valid", {63'h0, ireq_valid}, 64'h1);
      check("t3_stale_addr", ireq_addr, 64'h8000_0008);
    end
    grant_left = 1;
    @(negedge clk);
    check("t3_new_addr", ireq_addr, 64'h8000_0100);
    check("t3_out_valid", {63'h0, out_valid}, 64'h0);
    exp_q.push_back(64'h8000_0100);
    grant_left = 1;
    wait_drain("t3_drain");

    // 4: redirect coinciding with data_ok and a pop
    do_reset();
    out_ready  = 1'b0;
    grant_left = 1;
    repeat (3) @(negedge clk);
    check("t4_pre_out_valid", {63'h0, out_valid}, 64'h1);
    check("t4_pre_addr", ireq_addr, 64'h8000_0004);
    @(negedge clk);
    grant_left     = 1;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_out_valid", {63'h0, out_valid}, 64'h0);
    check("t4_ireq_valid", {63'h0, ireq_valid}, 64'h1);
    check("t4_ireq_addr", ireq_addr, 64'h0000_0200);
    exp_q.push_back(64'h0000_0200);
    grant_left = 1;
    wait_drain("t4_drain");

    // 5: two redirects during one DISCARD; only the last target is fetched
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t5_stale_addr", ireq_addr, PC_RESET);
    grant_left = 1;
    @(negedge clk);
    check("t5_new_addr", ireq_addr, 64'h0000_0200);
    exp_q.push_back(64'h0000_0200);
    grant_left = 1;
    wait_drain("t5_drain");

    // 6: reset while DISCARD is outstanding
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t6_discard_addr", ireq_addr, PC_RESET);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_out_valid", {63'h0, out_valid}, 64'h0);
    check("t6_ireq_valid", {63'h0, ireq_valid}, 64'h1);
    check("t6_ireq_addr", ireq_addr, PC_RESET);
    exp_q.push_back(PC_RESET);
    grant_left = 1;
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
